// File: rtl/minimig_autoconfig_pkg.sv
// Shared definitions for the autoconfig chain: register indices, FSM states,
// slot addressing and the power-up descriptor contents.
package minimig_autoconfig_pkg;

    // Register indices (bus address bits [6:1])
    localparam logic [5:0] REG_TYPE    = 6'h00;
    localparam logic [5:0] REG_SIZE    = 6'h01;
    localparam logic [5:0] REG_BASE_Z3 = 6'h22;
    localparam logic [5:0] REG_BASE_HI = 6'h24;
    localparam logic [5:0] REG_BASE_LO = 6'h25;
    localparam logic [5:0] REG_SHUTUP  = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } ac_state_e;

    // First nybble address of a slot's 64-entry descriptor window
    function automatic int unsigned slot_base(input int unsigned slot);
        return slot * 64;
    endfunction

    // Power-up nybble of one descriptor register, stored as the bus value.
    // Only type and size are filled in; product/vendor fields stay 0xF
    // until firmware patches them.
    function automatic logic [3:0] desc_default(input logic [5:0] reg_idx, input logic is_z3);
        logic [3:0] nyb;
        nyb = 4'hF;
        case (reg_idx)
            REG_TYPE: nyb = is_z3 ? 4'hA : 4'hE;
            REG_SIZE: nyb = is_z3 ? 4'h4 : 4'h0;
            default:  nyb = 4'hF;
        endcase
        return nyb;
    endfunction

endpackage

// File: rtl/minimig_autoconfig_desc_ram.sv
// Descriptor nybble storage for all slots: one registered read port whose
// output holds until the next read, plus the firmware patch write port.
// Read-first: a patch to the address being read returns the old nybble.
module minimig_autoconfig_desc_ram
    import minimig_autoconfig_pkg::*;
#(
    parameter int                    NUM_BOARDS = 4,
    parameter logic [NUM_BOARDS-1:0] BOARD_Z3   = 4'b0110,
    parameter int                    AW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [3:0]    dout,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [3:0]    wd
);
    localparam int DEPTH = 2 ** AW;

    typedef logic [3:0] mem_t [DEPTH];

    // Build power-up contents: everything 0xF, then each slot's table
    function automatic mem_t init_table();
        mem_t t;
        for (int i = 0; i < DEPTH; i++) begin
            t[i] = 4'hF;
        end
        for (int s = 0; s < NUM_BOARDS; s++) begin
            for (int r = 0; r < 64; r++) begin
                t[slot_base(s) + r] = desc_default(6'(r), BOARD_Z3[s]);
            end
        end
        return t;
    endfunction

    // Contents survive reset; only the power-up value is defined here
    mem_t mem_reg = init_table();

    logic [3:0] dout_reg;

    // Patch port write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wa] <= wd;
        end
    end

    // Registered read; output idles at 0xF (no board) after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= 4'hF;
        end else if (re) begin
            dout_reg <= mem_reg[ra];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/minimig_autoconfig_chain.sv
// Autoconfig chain controller: presents one enabled board at a time,
// serves descriptor reads, captures base/shut-up writes and walks the chain.
module minimig_autoconfig_chain
    import minimig_autoconfig_pkg::*;
#(
    parameter int                    NUM_BOARDS = 4,
    parameter logic [NUM_BOARDS-1:0] BOARD_Z3   = 4'b0110,
    parameter int                    AW         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_in,
    input  logic [NUM_BOARDS-1:0]         board_en,
    input  logic                          sel,
    input  logic                          rd,
    input  logic                          wr,
    input  logic [5:0]                    reg_a,
    input  logic [15:0]                   wdata,
    output logic [3:0]                    q,
    output logic                          q_valid,
    output logic                          active,
    output logic [$clog2(NUM_BOARDS)-1:0] cur_board,
    output logic [NUM_BOARDS-1:0]         configured,
    output logic [NUM_BOARDS-1:0]         shutup,
    output logic [NUM_BOARDS*16-1:0]      base,
    output logic                          cfg_done,
    input  logic                          patch_we,
    input  logic [AW-1:0]                 patch_a,
    input  logic [3:0]                    patch_d
);
    localparam int BW = $clog2(NUM_BOARDS);

    ac_state_e             state_reg, state_next;
    logic [BW-1:0]         cur_board_reg;
    logic [NUM_BOARDS-1:0] configured_reg;
    logic [NUM_BOARDS-1:0] shutup_reg;
    logic [15:0]           base_reg [NUM_BOARDS];
    logic [3:0]            pending_reg;
    logic [AW-1:0]         rd_addr_reg;
    logic                  rd_pend_reg;
    logic                  q_valid_reg;

    // cfg_in low behaves like reset for everything except descriptor contents
    logic clear;
    assign clear = reset | ~cfg_in;

    logic present, last_slot, cur_z3, wr_hit, rd_hit;
    logic do_lo, do_base_z2, do_base_z3, do_shut, advance, scan_skip;

    assign present    = (state_reg == ST_PRESENT);
    assign last_slot  = (cur_board_reg == BW'(NUM_BOARDS - 1));
    assign cur_z3     = BOARD_Z3[cur_board_reg];
    assign wr_hit     = present & sel & wr;
    assign rd_hit     = present & sel & rd & ~wr;   // write wins over read
    assign do_lo      = wr_hit & ~cur_z3 & (reg_a == REG_BASE_LO);
    assign do_base_z2 = wr_hit & ~cur_z3 & (reg_a == REG_BASE_HI);
    assign do_base_z3 = wr_hit &  cur_z3 & (reg_a == REG_BASE_Z3);
    assign do_shut    = wr_hit & (reg_a == REG_SHUTUP);
    assign advance    = do_base_z2 | do_base_z3 | do_shut;
    assign scan_skip  = (state_reg == ST_SCAN) & ~board_en[cur_board_reg] & ~last_slot;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one slot tested per clock while scanning
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cfg_in) state_next = ST_SCAN;
            ST_SCAN: begin
                if (board_en[cur_board_reg]) state_next = ST_PRESENT;
                else if (last_slot)          state_next = ST_DONE;
            end
            ST_PRESENT: if (advance) state_next = last_slot ? ST_DONE : ST_SCAN;
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        active   = present;
        cfg_done = (state_reg == ST_DONE);
    end

    // Slot pointer, captured bases and per-slot status
    always_ff @(posedge clk) begin
        if (clear) begin
            cur_board_reg  <= '0;
            configured_reg <= '0;
            shutup_reg     <= '0;
            pending_reg    <= '0;
            for (int i = 0; i < NUM_BOARDS; i++) begin
                base_reg[i] <= '0;
            end
        end else begin
            if (scan_skip) begin
                cur_board_reg <= cur_board_reg + BW'(1);
            end
            if (advance) begin
                pending_reg <= '0;
                if (!last_slot) begin
                    cur_board_reg <= cur_board_reg + BW'(1);
                end
            end else if (do_lo) begin
                pending_reg <= wdata[15:12];
            end
            if (do_base_z2) begin
                base_reg[cur_board_reg]       <= {8'h00, wdata[15:12], pending_reg};
                configured_reg[cur_board_reg] <= 1'b1;
            end
            if (do_base_z3) begin
                base_reg[cur_board_reg]       <= wdata;
                configured_reg[cur_board_reg] <= 1'b1;
            end
            if (do_shut) begin
                shutup_reg[cur_board_reg] <= 1'b1;
            end
        end
    end

    // Read pipeline: address registered, then array read, then q_valid
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_pend_reg <= 1'b0;
            rd_addr_reg <= '0;
            q_valid_reg <= 1'b0;
        end else begin
            rd_pend_reg <= rd_hit;
            if (rd_hit) begin
                rd_addr_reg <= {cur_board_reg, reg_a};
            end
            q_valid_reg <= rd_pend_reg;
        end
    end

    minimig_autoconfig_desc_ram #(
        .NUM_BOARDS (NUM_BOARDS),
        .BOARD_Z3   (BOARD_Z3),
        .AW         (AW)
    ) u_desc_ram (
        .clk   (clk),
        .reset (clear),
        .re    (rd_pend_reg),
        .ra    (rd_addr_reg),
        .dout  (q),
        .we    (patch_we),
        .wa    (patch_a),
        .wd    (patch_d)
    );

    for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_base
        assign base[gi*16 +: 16] = base_reg[gi];
    end

    assign q_valid    = q_valid_reg;
    assign cur_board  = cur_board_reg;
    assign configured = configured_reg;
    assign shutup     = shutup_reg;

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Directed bench for the autoconfig chain: walks a 4-slot chain through
// Z2 and Z3 configuration, skip, shut-up, patching and mid-chain reset.
module tb_minimig_autoconfig_chain;

    logic        clk = 1'b0;
    logic        reset, cfg_in;
    logic [3:0]  board_en;
    logic        sel, rd, wr;
    logic [5:0]  reg_a;
    logic [15:0] wdata;
    logic [3:0]  q;
    logic        q_valid, active, cfg_done;
    logic [1:0]  cur_board;
    logic [3:0]  configured, shutup;
    logic [63:0] base;
    logic        patch_we;
    logic [7:0]  patch_a;
    logic [3:0]  patch_d;

    int checks_total = 0;
    int checks_pass  = 0;

    always #5 clk = ~clk;

    minimig_autoconfig_chain #(
        .NUM_BOARDS (4),
        .BOARD_Z3   (4'b0110),
        .AW         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_in     (cfg_in),
        .board_en   (board_en),
        .sel        (sel),
        .rd         (rd),
        .wr         (wr),
        .reg_a      (reg_a),
        .wdata      (wdata),
        .q          (q),
        .q_valid    (q_valid),
        .active     (active),
        .cur_board  (cur_board),
        .configured (configured),
        .shutup     (shutup),
        .base       (base),
        .cfg_done   (cfg_done),
        .patch_we   (patch_we),
        .patch_a    (patch_a),
        .patch_d    (patch_d)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            checks_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_active"},     active,     1'b0);
        check({tag, "_q"},          q,          4'hF);
        check({tag, "_q_valid"},    q_valid,    1'b0);
        check({tag, "_configured"}, configured, 4'b0000);
        check({tag, "_shutup"},     shutup,     4'b0000);
        check({tag, "_base"},       base,       64'h0);
        check({tag, "_cfg_done"},   cfg_done,   1'b0);
        check({tag, "_cur_board"},  cur_board,  2'd0);
    endtask

    // Read one register; q_valid must rise exactly two cycles after rd
    task automatic bus_read(input logic [5:0] r, input logic [3:0] exp, input string tag);
        $display("rd  slot %0d reg %02h expect %h", cur_board, r, exp);
        sel = 1'b1; rd = 1'b1; reg_a = r;
        step();
        sel = 1'b0; rd = 1'b0;
        check({tag, "_qv_c1"}, q_valid, 1'b0);
        step();
        check({tag, "_qv_c2"}, q_valid, 1'b1);
        check({tag, "_q"},     q,       exp);
        step();
        check({tag, "_qv_c3"}, q_valid, 1'b0);
    endtask

    task automatic bus_write(input logic [5:0] r, input logic [15:0] d);
        $display("wr  slot %0d reg %02h data %04h", cur_board, r, d);
        sel = 1'b1; wr = 1'b1; reg_a = r; wdata = d;
        step();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic wait_active(input string tag);
        for (int n = 0; n < 8 && !active; n++) step();
        check(tag, active, 1'b1);
    endtask

    initial begin
        reset = 1'b1; cfg_in = 1'b0; board_en = 4'b1111;
        sel = 1'b0; rd = 1'b0; wr = 1'b0; reg_a = '0; wdata = '0;
        patch_we = 1'b0; patch_a = '0; patch_d = '0;
        repeat (3) step();
        check_reset_state("rst");

        // Start the chain: IDLE -> SCAN -> PRESENT slot 0
        reset = 1'b0; cfg_in = 1'b1;
        step();
        check("scan_inactive", active, 1'b0);
        step();
        check("s0_active", active, 1'b1);
        check("s0_cur", cur_board, 2'd0);
        bus_read(6'h00, 4'hE, "s0_type");

        // Slot 0, Zorro II: low nybble then high nybble
        bus_write(6'h25, 16'h0000);
        bus_write(6'h24, 16'h2000);
        check("s0_adv_active", active, 1'b0);
        check("s0_configured", configured, 4'b0001);
        check("s0_base", base[15:0], 16'h0020);
        check("s0_adv_cur", cur_board, 2'd1);
        step();
        check("s1_active", active, 1'b1);
        check("s1_cur", cur_board, 2'd1);

        // Slot 1, Zorro III: initial size nybble, Z2 writes ignored
        bus_read(6'h01, 4'h4, "s1_size_init");
        bus_write(6'h25, 16'hF000);
        bus_write(6'h24, 16'h3000);
        check("s1_z2_active", active, 1'b1);
        check("s1_z2_configured", configured, 4'b0001);
        check("s1_z2_cur", cur_board, 2'd1);
        check("s1_z2_base", base[31:16], 16'h0000);

        // Patch lands on the array-read edge: read returns the old nybble
        $display("rd  slot 1 reg 01 with patch 41<=7 on array-read edge");
        sel = 1'b1; rd = 1'b1; reg_a = 6'h01;
        step();
        sel = 1'b0; rd = 1'b0;
        patch_we = 1'b1; patch_a = 8'h41; patch_d = 4'h7;
        step();
        patch_we = 1'b0;
        check("patch_same_cycle_qv", q_valid, 1'b1);
        check("patch_same_cycle_old", q, 4'h4);
        step();
        bus_read(6'h01, 4'h7, "s1_size_patched");

        // Slot 1 base, then slot 2 disabled and skipped
        board_en = 4'b1011;
        bus_write(6'h22, 16'h4000);
        check("s1_adv_active", active, 1'b0);
        check("s1_configured", configured, 4'b0011);
        check("s1_base", base[31:16], 16'h4000);
        check("s1_adv_cur", cur_board, 2'd2);
        step();
        check("skip_cur", cur_board, 2'd3);
        check("skip_active", active, 1'b0);
        step();
        check("s3_active", active, 1'b1);
        check("s3_cur", cur_board, 2'd3);

        // Slot 3 shut up: chain done
        bus_write(6'h26, 16'h0000);
        check("s3_shutup", shutup, 4'b1000);
        check("s3_configured", configured, 4'b0011);
        check("done_base", base, 64'h0000_0000_4000_0020);
        check("done_cfg_done", cfg_done, 1'b1);
        check("done_active", active, 1'b0);

        // Reads outside PRESENT produce nothing; q holds
        $display("rd  in DONE reg 00");
        sel = 1'b1; rd = 1'b1; reg_a = 6'h00;
        step();
        sel = 1'b0; rd = 1'b0;
        step();
        check("done_no_qv", q_valid, 1'b0);
        check("done_q_hold", q, 4'h7);

        // Restart with slots 0,1 absent: slot 2 presented
        reset = 1'b1;
        step();
        reset = 1'b0; board_en = 4'b1100;
        wait_active("s2_active");
        check("s2_cur", cur_board, 2'd2);
        bus_read(6'h00, 4'hA, "s2_type");

        // Reset mid-PRESENT
        reset = 1'b1;
        step();
        check_reset_state("mid_rst");
        reset = 1'b0; board_en = 4'b1111;
        wait_active("r_s0_active");
        bus_write(6'h26, 16'h0000);
        check("r_s0_shutup", shutup, 4'b0001);
        wait_active("r_s1_active");
        bus_read(6'h01, 4'h7, "patch_retained");

        // cfg_in low mid-PRESENT clears state
        cfg_in = 1'b0;
        step();
        check("cfg_low_active", active, 1'b0);
        check("cfg_low_shutup", shutup, 4'b0000);
        check("cfg_low_cur", cur_board, 2'd0);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
